// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and round-robin helper for the FIFO write-port arbiter.
// The picker function is sized for up to RR_MAX requesters; callers pad and truncate.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = $clog2(RR_MAX);

  // Rotate req so ptr lands at bit 0, take the lowest set bit, rotate the hit back.
  // Returns a one-hot grant (all zero when req is empty) over the low n bits.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       n);
    logic [RR_MAX-1:0] rot;
    logic [RR_MAX-1:0] hit;
    logic [RR_MAX-1:0] gnt;
    logic              found;
    int unsigned       idx;
    rot   = '0;
    hit   = '0;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        idx = i + ptr;
        if (idx >= n) idx = idx - n;
        rot[i] = req[idx[RR_IW-1:0]];
      end
    end
    for (int i = 0; i < RR_MAX; i++) begin
      if (rot[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < RR_MAX; i++) begin
      if (hit[i] && (i < n)) begin
        idx = i + ptr;
        if (idx >= n) idx = idx - n;
        gnt[idx[RR_IW-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side bundle for the write-port arbiter.
// master = arbiter view, slave = the surrounding requesters/FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_w_en;
  logic [WIDTH-1:0]         fifo_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     frame_err;
  logic [CNT_W-1:0]         frame_cnt;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_w_en, fifo_data, grant, busy, frame_err, frame_cnt
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_w_en, fifo_data, grant, busy, frame_err, frame_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping,
// returned one-hot.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  assign grant = NUM_REQ'(rr_pick(RR_MAX'(req), 32'(ptr), NUM_REQ));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter in front of the async FIFO write port.
// Holds a grant for a whole frame; closes on last beat or at MAX_BEATS.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 1518,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               arst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [PTR_W-1:0]    gidx_reg, gidx_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0]    frame_cnt_reg, frame_cnt_next;
  logic                frame_err_reg, frame_err_next;

  logic [NUM_REQ-1:0]  pick;
  logic [PTR_W-1:0]    pick_idx;
  logic [WIDTH-1:0]    beat_data [NUM_REQ];
  logic                locked;
  logic                sel_valid;
  logic                sel_last;
  logic                accept;
  logic                at_limit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign beat_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick)
  );

  // Picker output is one-hot, so OR-ing indices yields the binary index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = pick_idx | PTR_W'(i);
    end
  end

  assign locked    = (state_reg == LOCKED);
  assign sel_valid = bus.req_valid[gidx_reg];
  assign sel_last  = bus.req_last[gidx_reg];
  assign accept    = locked & sel_valid & ~bus.fifo_full;
  assign at_limit  = (beat_cnt_reg == LAST_BEAT);

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    gidx_next      = gidx_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    frame_err_next = 1'b0;
    bus.req_ready  = '0;
    bus.fifo_w_en  = 1'b0;
    bus.fifo_data  = '0;

    case (state_reg)
      IDLE: begin
        if (|bus.req_valid) begin
          state_next = LOCKED;
          grant_next = pick;
          gidx_next  = pick_idx;
        end
      end
      LOCKED: begin
        bus.req_ready = grant_reg & {NUM_REQ{~bus.fifo_full}};
        bus.fifo_w_en = accept;
        bus.fifo_data = beat_data[gidx_reg];
        if (accept) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          // A length-limit close is flagged only when the beat was not a real last.
          if (sel_last || at_limit) begin
            state_next     = IDLE;
            grant_next     = '0;
            beat_cnt_next  = '0;
            frame_cnt_next = frame_cnt_reg + 1'b1;
            rr_ptr_next    = (gidx_reg == LAST_PTR) ? '0 : gidx_reg + 1'b1;
            frame_err_next = ~sel_last;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      gidx_reg      <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      gidx_reg      <= gidx_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.busy      = locked;
  assign bus.frame_err = frame_err_reg;
  assign bus.frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: 4 requesters, MAX_BEATS=4, 4-bit frame counter.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   wr_count = 0;
  int   full_viol = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arst_n && bus.fifo_w_en) begin
      wr_count++;
      if (bus.fifo_full) full_viol++;
      $display("wr t=%0t grant=%b data=%h", $time, bus.grant, bus.fifo_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic f);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
    bus.fifo_full = f;
  endtask

  task automatic do_reset;
    arst_n = 1'b0;
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    #1;
    tick;
    arst_n = 1'b1;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    drive(4'b1111, 32'hAABBCCDD, 4'b1111, 1'b0);
    tick;
    tick;
    total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
    total++; if (bus.fifo_w_en !== 1'b0) begin bad++; $display("FAIL reset_w_en got=%b exp=0", bus.fifo_w_en); end
    total++; if (bus.fifo_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.fifo_data); end
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.frame_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.frame_cnt); end
    total++; if ({bus.busy, bus.frame_err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b exp=00", {bus.busy, bus.frame_err}); end
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    arst_n = 1'b1;
    tick;
    #1;
    total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL idle_no_req_grant got=%b exp=0000", bus.grant); end
    tick;
  endtask

  task automatic test_single;
    logic [3:0] v_t  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    logic [7:0] d_t  [5] = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [3:0] l_t  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic [3:0] eg_t [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    logic       ew_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed_t [5] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    for (int c = 0; c < 5; c++) begin
      drive(v_t[c], {24'h0, d_t[c]}, l_t[c], 1'b0);
      #1;
      total++; if (bus.grant !== eg_t[c]) begin bad++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, bus.grant, eg_t[c]); end
      total++; if (bus.fifo_w_en !== ew_t[c]) begin bad++; $display("FAIL single_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, ew_t[c]); end
      total++; if (bus.fifo_data !== ed_t[c]) begin bad++; $display("FAIL single_data c=%0d got=%h exp=%h", c, bus.fifo_data, ed_t[c]); end
      total++; if (bus.req_ready !== eg_t[c]) begin bad++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, bus.req_ready, eg_t[c]); end
      tick;
    end
    total++; if (bus.frame_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", bus.frame_cnt); end
  endtask

  task automatic test_fairness;
    int          pos [4] = '{0, 0, 0, 0};
    logic [31:0] d;
    logic [3:0]  l;
    logic [3:0]  acc;
    logic [3:0]  eg;
    logic        ew;
    logic [7:0]  ed;
    int          f, ph, r, k;
    do_reset;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < 4; i++) begin
        d[i*8 +: 8] = {4'(i), 4'(pos[i])};
        l[i]        = pos[i][0];
      end
      drive(4'b1111, d, l, 1'b0);
      f  = c / 3;
      ph = c % 3;
      r  = f % 4;
      k  = f / 4;
      eg = (ph == 0) ? 4'b0 : 4'(1 << r);
      ew = (ph != 0);
      ed = (ph == 0) ? 8'h00 : {4'(r), 4'(2 * k + ph - 1)};
      #1;
      total++; if (bus.grant !== eg) begin bad++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
      total++; if (bus.fifo_w_en !== ew) begin bad++; $display("FAIL fair_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, ew); end
      total++; if (bus.fifo_data !== ed) begin bad++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, bus.fifo_data, ed); end
      acc = bus.req_ready & bus.req_valid;
      tick;
      for (int i = 0; i < 4; i++) if (acc[i]) pos[i]++;
    end
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    #1;
    total++; if (bus.frame_cnt !== 4'd5) begin bad++; $display("FAIL fair_cnt got=%0d exp=5", bus.frame_cnt); end
    tick;
  endtask

  task automatic test_backpressure;
    int   b = 0;
    int   w0;
    logic full;
    logic [3:0] er;
    w0 = wr_count;
    drive(4'b0010, 32'h0000A000, 4'b0, 1'b0);
    #1;
    total++; if (bus.fifo_w_en !== 1'b0) begin bad++; $display("FAIL bp_idle_w_en got=%b exp=0", bus.fifo_w_en); end
    tick;
    for (int c = 0; c < 8; c++) begin
      full = (c % 2 == 0);
      drive(4'b0010, {16'h0, 8'(8'hA0 + b), 8'h0}, (b == 3) ? 4'b0010 : 4'b0, full);
      er = full ? 4'b0000 : 4'b0010;
      #1;
      total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL bp_grant c=%0d got=%b exp=0010", c, bus.grant); end
      total++; if (bus.fifo_w_en !== !full) begin bad++; $display("FAIL bp_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, !full); end
      total++; if (bus.req_ready !== er) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, bus.req_ready, er); end
      total++; if (bus.fifo_data !== 8'(8'hA0 + c / 2)) begin bad++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, bus.fifo_data, 8'(8'hA0 + c / 2)); end
      tick;
      if (!full) b++;
    end
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    #1;
    total++; if (wr_count - w0 != 4) begin bad++; $display("FAIL bp_writes got=%0d exp=4", wr_count - w0); end
    total++; if (full_viol != 0) begin bad++; $display("FAIL bp_write_while_full got=%0d exp=0", full_viol); end
    total++; if (bus.frame_cnt !== 4'd6) begin bad++; $display("FAIL bp_cnt got=%0d exp=6", bus.frame_cnt); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL bp_err got=%b exp=0", bus.frame_err); end
    tick;
  endtask

  task automatic test_forced;
    logic [3:0] eg_t [9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic       ew_t [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed_t [9] = '{8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'hC5, 8'hC6, 8'h00};
    logic       ee_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   b = 0;
    logic acc;
    for (int c = 0; c < 9; c++) begin
      drive((b < 6) ? 4'b0100 : 4'b0, {8'h0, 8'(8'hC1 + b), 16'h0}, (b == 5) ? 4'b0100 : 4'b0, 1'b0);
      #1;
      total++; if (bus.grant !== eg_t[c]) begin bad++; $display("FAIL forced_grant c=%0d got=%b exp=%b", c, bus.grant, eg_t[c]); end
      total++; if (bus.fifo_w_en !== ew_t[c]) begin bad++; $display("FAIL forced_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, ew_t[c]); end
      total++; if (bus.fifo_data !== ed_t[c]) begin bad++; $display("FAIL forced_data c=%0d got=%h exp=%h", c, bus.fifo_data, ed_t[c]); end
      total++; if (bus.frame_err !== ee_t[c]) begin bad++; $display("FAIL forced_err c=%0d got=%b exp=%b", c, bus.frame_err, ee_t[c]); end
      acc = bus.req_ready[2] & bus.req_valid[2];
      tick;
      if (acc) b++;
    end
    total++; if (bus.frame_cnt !== 4'd8) begin bad++; $display("FAIL forced_cnt got=%0d exp=8", bus.frame_cnt); end
  endtask

  task automatic test_stall;
    logic [3:0]  v_t  [11] = '{4'b0010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0]  l_t  [11] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1010, 4'b1000, 4'b1000, 4'b0000};
    logic [7:0]  b_t  [11] = '{8'hB0, 8'hB0, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
                               8'hB1, 8'hB1, 8'hB1, 8'hB1};
    logic [3:0]  eg_t [11] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                               4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic        ew_t [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  ed_t [11] = '{8'h00, 8'hB0, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1,
                               8'hB1, 8'h00, 8'hD0, 8'h00};
    for (int c = 0; c < 11; c++) begin
      drive(v_t[c], {8'hD0, 8'h00, b_t[c], 8'h00}, l_t[c], 1'b0);
      #1;
      total++; if (bus.grant !== eg_t[c]) begin bad++; $display("FAIL stall_grant c=%0d got=%b exp=%b", c, bus.grant, eg_t[c]); end
      total++; if (bus.fifo_w_en !== ew_t[c]) begin bad++; $display("FAIL stall_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, ew_t[c]); end
      total++; if (bus.fifo_data !== ed_t[c]) begin bad++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, bus.fifo_data, ed_t[c]); end
      tick;
    end
    total++; if (bus.frame_cnt !== 4'd10) begin bad++; $display("FAIL stall_cnt got=%0d exp=10", bus.frame_cnt); end
  endtask

  task automatic test_reset_mid;
    drive(4'b0100, 32'h00E00000, 4'b0100, 1'b0);
    tick;
    #1;
    total++; if (bus.fifo_data !== 8'hE0) begin bad++; $display("FAIL rmid_first_data got=%h exp=e0", bus.fifo_data); end
    tick;
    drive(4'b1000, 32'hF1000000, 4'b0, 1'b0);
    tick;
    #1;
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL rmid_grant_before got=%b exp=1000", bus.grant); end
    total++; if (bus.frame_cnt !== 4'd11) begin bad++; $display("FAIL rmid_cnt_before got=%0d exp=11", bus.frame_cnt); end
    tick;
    drive(4'b1000, 32'hF2000000, 4'b0, 1'b0);
    arst_n = 1'b0;
    #1;
    total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL rmid_grant got=%b exp=0000", bus.grant); end
    total++; if (bus.fifo_w_en !== 1'b0) begin bad++; $display("FAIL rmid_w_en got=%b exp=0", bus.fifo_w_en); end
    total++; if (bus.fifo_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", bus.fifo_data); end
    total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.frame_cnt !== 4'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", bus.frame_cnt); end
    drive(4'b1010, 32'hF2005100, 4'b0, 1'b0);
    tick;
    arst_n = 1'b1;
    #1;
    total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL rmid_idle_grant got=%b exp=0000", bus.grant); end
    tick;
    #1;
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL rmid_regrant got=%b exp=0010", bus.grant); end
    total++; if (bus.fifo_data !== 8'h51) begin bad++; $display("FAIL rmid_regrant_data got=%h exp=51", bus.fifo_data); end
    do_reset;
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 32; c++) begin
      drive(4'b0001, 32'h00000077, 4'b0001, 1'b0);
      #1;
      total++; if (bus.fifo_w_en !== (c % 2 == 1)) begin bad++; $display("FAIL b2b_w_en c=%0d got=%b exp=%b", c, bus.fifo_w_en, (c % 2 == 1)); end
      if (c == 30) begin
        total++; if (bus.frame_cnt !== 4'd15) begin bad++; $display("FAIL b2b_cnt_max got=%0d exp=15", bus.frame_cnt); end
      end
      tick;
    end
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    #1;
    total++; if (bus.frame_cnt !== 4'd0) begin bad++; $display("FAIL b2b_cnt_wrap got=%0d exp=0", bus.frame_cnt); end
    tick;
  endtask

  initial begin
    drive(4'b0, 32'h0, 4'b0, 1'b0);
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_forced;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Frame-granular round-robin arbiter that shares the single write port of the async FIFO between NUM_REQ requesters, all in the write-clock domain.
- Grants one requester at a time and holds the grant until that requester's last beat is accepted.
- Gates writes on FIFO full and enforces a maximum frame length.
- Sits directly in front of the FIFO's w_en/data_in/full interface, on the MAC TX path.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data beat width; equals FIFO WIDTH
MAX_BEATS, 1518, maximum beats per frame before forced close
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  write-domain clock (connects to FIFO wclk)
arst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*WIDTH  packed beats; requester i at [i*WIDTH +: WIDTH]
req_last  in  NUM_REQ  per-requester last-beat flag
req_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid
fifo_full  in  1  FIFO full flag
fifo_w_en  out  1  FIFO write enable
fifo_data  out  WIDTH  FIFO write data
grant  out  NUM_REQ  one-hot current owner; all zero when idle
busy  out  1  high in LOCKED state
frame_err  out  1  one-cycle pulse on forced close at MAX_BEATS
frame_cnt  out  CNT_W  frames completed (normal or forced), wraps

Behaviour:
- Reset (async assert, released on a clk edge) clears all of the following:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, frame_cnt=0.
  - frame_err=0, req_ready=0, fifo_w_en=0, fifo_data=0.
- Beat accepted = LOCKED & req_valid[g] & ~fifo_full, where g is the granted index.
- IDLE state:
  - req_ready=0, fifo_w_en=0.
  - If any req_valid is high, select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Register grant one-hot; go to LOCKED on the next edge.
  - Arbitration latency is 1 cycle: no beat is accepted in the IDLE cycle.
- LOCKED state:
  - req_ready[g] = ~fifo_full; every other req_ready bit is 0.
  - fifo_w_en = req_valid[g] & ~fifo_full (combinational, zero added latency).
  - fifo_data = req_data of g, muxed combinationally.
  - fifo_data is 0 whenever not LOCKED.
  - On each accepted beat, beat_cnt increments.
- Normal frame end: accepted beat with req_last[g]=1.
  - frame_cnt+1, rr_ptr <= (g+1) mod NUM_REQ, grant cleared, beat_cnt=0, go to IDLE.
  - There is exactly one IDLE cycle between frames.
- Forced close: accepted beat where beat_cnt==MAX_BEATS-1 and req_last[g]=0.
  - Same actions as normal end, plus frame_err=1 for one cycle (the cycle after the beat).
  - The requester's remaining beats are handled as a new frame on its next grant.
- fifo_full high in LOCKED: nothing is accepted, state is held, and the requester must hold its data.
  - fifo_full may toggle every cycle; each accepted beat is counted exactly once.
- req_valid[g] dropping mid-frame: grant is held indefinitely; other requesters wait; there is no timeout.
- Requests from non-granted requesters while LOCKED are ignored and have no effect on rr_ptr.
- Requester g reasserting immediately after its frame end is not favoured: rr_ptr has already advanced past it.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-frame: immediate return to reset values; the partial frame already in the FIFO is the FIFO's concern, since the FIFO is reset by the same arst_n.
- Arithmetic:
  - beat_cnt width is $clog2(MAX_BEATS+1).
  - rr_ptr width is $clog2(NUM_REQ).
  - rr_ptr wrap is an explicit compare, not a power-of-two mask.

Decomposition:
- Package fifo_arb_pkg holds the arb_state_e enum (IDLE, LOCKED) and a function rr_pick(req, ptr) returning a one-hot grant.
- One sub-module, rr_picker: combinational rotate, priority-encode, rotate back, parameterised on NUM_REQ.
- The FSM, counters and datapath mux stay in fifo_wr_arbiter.

Test Plan:
- Single frame, no backpressure: req0 sends 3 beats 0x11,0x22,0x33 with last on the third beat -> grant=0001 after 1 cycle; fifo_w_en high for 3 consecutive cycles with data 0x11,0x22,0x33; frame_cnt=1; IDLE one cycle.
- Fairness: all 4 requesters valid continuously with 2-beat frames -> grant order 0,1,2,3,0; each frame contiguous; frame_cnt=5 after 5 frames.
- Full backpressure: fifo_full high on alternate cycles during a 4-beat frame -> exactly 4 fifo_w_en pulses; fifo_w_en never high while fifo_full is high; req_ready mirrors ~fifo_full.
- Forced close: MAX_BEATS=4, req2 streams 6 beats with last on beat 6 -> close after beat 4; frame_err pulses once; after re-grant the 2 remaining beats are written; frame_cnt=2.
- Mid-frame stall: req1 drops valid for 5 cycles mid-frame while req3 is valid -> grant stays 0010; zero writes during the stall; req3 is granted only after req1's last beat.
- Reset mid-frame: assert arst_n low during beat 2 of a frame -> all outputs 0 immediately; after release, first grant goes to the lowest valid index (rr_ptr=0).
